// File: rtl/frac_sf_norm_pipe_if.sv
// Handshake/data bundle for frac_sf_norm_pipe.
//   slave  : the normaliser (consumes input beat, produces result)
//   master : the environment (drives input beat, accepts result)
// Signals: flush_i, in_valid_i/in_ready_o, acc_sign_i, acc_hd_i, acc_s0_i..acc_s3_i,
//          out_valid_o/out_ready_i, sign_o, sf_o, mts_o, ovf_o, udf_o, nzero_o,
//          sticky_o (only when FRAC_SF_STICKY_EN is defined).
interface frac_sf_norm_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int K        = 9,
  parameter int EXP      = 2,
  parameter int ACC      = (2**EXP)*(WIDTH-2),
  parameter int ACC_HEAD = $clog2(K)+2,
  parameter int MW       = 2*(WIDTH-3-EXP)+2,
  parameter int SFW      = $clog2(ACC)+2
);
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  acc_sign_i;
  logic [ACC_HEAD-1:0]   acc_hd_i;
  logic [ACC-1:0]        acc_s0_i;
  logic [ACC-1:0]        acc_s1_i;
  logic [ACC-1:0]        acc_s2_i;
  logic [ACC-1:0]        acc_s3_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  sign_o;
  logic signed [SFW-1:0] sf_o;
  logic [MW-1:0]         mts_o;
  logic                  ovf_o;
  logic                  udf_o;
  logic                  nzero_o;
`ifdef FRAC_SF_STICKY_EN
  logic                  sticky_o;
`endif

  modport master (
    output flush_i, in_valid_i, acc_sign_i, acc_hd_i,
           acc_s0_i, acc_s1_i, acc_s2_i, acc_s3_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_o, sf_o, mts_o, ovf_o, udf_o, nzero_o
`ifdef FRAC_SF_STICKY_EN
    , sticky_o
`endif
  );

  modport slave (
    input  flush_i, in_valid_i, acc_sign_i, acc_hd_i,
           acc_s0_i, acc_s1_i, acc_s2_i, acc_s3_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_o, sf_o, mts_o, ovf_o, udf_o, nzero_o
`ifdef FRAC_SF_STICKY_EN
    , sticky_o
`endif
  );
endinterface

// File: rtl/frac_sf_norm_pipe.sv
// Two-stage scale-factor/mantissa normaliser for a segmented quire accumulator.
// Stage 1 classifies the accumulator (OVF/POS/NEG/UDF/ZERO) and picks the
// segment pair holding the leading one; stage 2 counts leading zeros and
// emits scale factor, normalised mantissa and flags. Valid/ready on both sides.
// Ports: clk_i, rst (sync, active-high), bus (frac_sf_norm_pipe_if.slave).
// Macro FRAC_SF_STICKY_EN adds sticky_o (OR of bits discarded below mantissa).
module frac_sf_norm_pipe #(
  parameter int WIDTH    = 8,
  parameter int K        = 9,
  parameter int EXP      = 2,
  parameter int ACC      = (2**EXP)*(WIDTH-2),
  parameter int ACC_HEAD = $clog2(K)+2,
  parameter int MW       = 2*(WIDTH-3-EXP)+2,
  parameter int SFW      = $clog2(ACC)+2
) (
  input  logic               clk_i,
  input  logic               rst,
  frac_sf_norm_pipe_if.slave bus
);
  localparam int ZW = $clog2(ACC);
  localparam int PW = 2*ACC;

  typedef enum logic [2:0] {CLS_ZERO, CLS_OVF, CLS_POS, CLS_NEG, CLS_UDF} cls_e;

  // stage 1
  logic           v1, sign1;
  cls_e           cls1;
  logic [ACC-1:0] hi1, lo1;
  // stage 2 (registered outputs)
  logic                  v2, sign2, ovf2, udf2, nzero2;
  logic signed [SFW-1:0] sf2;
  logic [MW-1:0]         mts2;

  logic adv1, adv2, accept;
  cls_e           in_cls;
  logic [ACC-1:0] in_hi, in_lo;

  assign adv2   = ~v2 | bus.out_ready_i;
  assign adv1   = adv2 | ~v1;
  assign bus.in_ready_o = ~rst & ~bus.flush_i & (~v1 | ~v2 | bus.out_ready_i);
  assign accept = bus.in_valid_i & bus.in_ready_o;

  always_comb begin
    in_cls = CLS_ZERO;
    in_hi  = '0;
    in_lo  = '0;
    if (|bus.acc_hd_i)      in_cls = CLS_OVF;
    else if (|bus.acc_s0_i) in_cls = CLS_OVF;
    else if (|bus.acc_s1_i) begin
      in_cls = CLS_POS;
      in_hi  = bus.acc_s1_i;
      in_lo  = bus.acc_s2_i;
    end else if (|bus.acc_s2_i) begin
      in_cls = CLS_NEG;
      in_hi  = bus.acc_s2_i;
      in_lo  = bus.acc_s3_i;
    end else if (|bus.acc_s3_i) in_cls = CLS_UDF;
  end

  // Leading-zero count: later (higher) set bits overwrite earlier ones.
  logic [ZW-1:0] zc;
  always_comb begin
    zc = '0;
    for (int unsigned i = 0; i < ACC; i++)
      if (hi1[i]) zc = ZW'(ACC - 1 - i);
  end

  logic [PW-1:0]         shifted;
  logic signed [SFW-1:0] sf_n;
  logic [MW-1:0]         mts_n;
  logic                  ovf_n, udf_n, nzero_n;

  assign shifted = {hi1, lo1} << zc;

  always_comb begin
    sf_n    = '0;
    mts_n   = '0;
    ovf_n   = 1'b0;
    udf_n   = 1'b0;
    nzero_n = 1'b1;
    case (cls1)
      CLS_OVF:  ovf_n = 1'b1;
      CLS_UDF:  udf_n = 1'b1;
      CLS_ZERO: begin udf_n = 1'b1; nzero_n = 1'b0; end
      CLS_POS: begin
        sf_n  = SFW'(ACC - 1) - SFW'(zc);
        mts_n = MW'(shifted >> (PW - MW));
      end
      CLS_NEG: begin
        sf_n  = -SFW'(zc) - SFW'(1);
        mts_n = MW'(shifted >> (PW - MW));
      end
      default: ;
    endcase
  end

`ifdef FRAC_SF_STICKY_EN
  localparam logic [PW-1:0] LOW_MASK = {PW{1'b1}} >> MW;
  // For POS the pair is {s1,s2}, so all of s3 lies below the window too.
  logic xs1, sticky2, sticky_n;
  assign sticky_n = ((cls1 == CLS_POS) || (cls1 == CLS_NEG)) ?
                    ((|(shifted & LOW_MASK)) | xs1) : 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (bus.flush_i) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= accept;
      if (accept) begin
        sign1 <= bus.acc_sign_i;
        cls1  <= in_cls;
        hi1   <= in_hi;
        lo1   <= in_lo;
`ifdef FRAC_SF_STICKY_EN
        xs1   <= (in_cls == CLS_POS) & (|bus.acc_s3_i);
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      v2     <= 1'b0;
      sign2  <= 1'b0;
      sf2    <= '0;
      mts2   <= '0;
      ovf2   <= 1'b0;
      udf2   <= 1'b0;
      nzero2 <= 1'b1;
`ifdef FRAC_SF_STICKY_EN
      sticky2 <= 1'b0;
`endif
    end else if (bus.flush_i) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        sign2  <= sign1;
        sf2    <= sf_n;
        mts2   <= mts_n;
        ovf2   <= ovf_n;
        udf2   <= udf_n;
        nzero2 <= nzero_n;
`ifdef FRAC_SF_STICKY_EN
        sticky2 <= sticky_n;
`endif
      end
    end
  end

  assign bus.out_valid_o = v2;
  assign bus.sign_o      = sign2;
  assign bus.sf_o        = sf2;
  assign bus.mts_o       = mts2;
  assign bus.ovf_o       = ovf2;
  assign bus.udf_o       = udf2;
  assign bus.nzero_o     = nzero2;
`ifdef FRAC_SF_STICKY_EN
  assign bus.sticky_o    = sticky2;
`endif
endmodule

// File: tb/tb_frac_sf_norm_pipe.sv
module tb_frac_sf_norm_pipe;
  localparam int ACC  = 24;
  localparam int MW   = 8;
  localparam int HEAD = 6;
  localparam int PW   = 2*ACC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frac_sf_norm_pipe_if bus ();
  frac_sf_norm_pipe #(.WIDTH(8), .K(9), .EXP(2)) dut (
    .clk_i(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic sign; int sf; logic [MW-1:0] mts;
    logic ovf; logic udf; logic nzero; logic sticky;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference: scale factor = bit position of leading one relative to the
  // s1/s2 boundary; mantissa = pair shifted until its MSB is one.
  function automatic exp_t model(logic sg, logic [HEAD-1:0] hd,
                                 logic [ACC-1:0] s0, logic [ACC-1:0] s1,
                                 logic [ACC-1:0] s2, logic [ACC-1:0] s3);
    exp_t e;
    logic [PW-1:0] p;
    logic [ACC-1:0] v;
    int lg;
    e.sign = sg; e.sf = 0; e.mts = '0; e.ovf = 0; e.udf = 0; e.nzero = 1; e.sticky = 0;
    if (hd != 0 || s0 != 0) e.ovf = 1;
    else if (s1 != 0 || s2 != 0) begin
      v = (s1 != 0) ? s1 : s2;
      p = (s1 != 0) ? {s1, s2} : {s2, s3};
      lg = 0;
      while (v > 1) begin v = v >> 1; lg++; end
      e.sf = (s1 != 0) ? lg : lg - ACC;
      while (p[PW-1] == 1'b0) p = p << 1;
      e.mts = p[PW-1 -: MW];
      e.sticky = ((p << MW) != 0) || (s1 != 0 && s3 != 0);
    end else begin
      e.udf = 1;
      e.nzero = (s3 != 0);
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: scoreboard order/content and stall stability.
  logic [63:0] held;
  logic        was_stall = 1'b0;
  always @(negedge clk) begin
    logic [63:0] cur;
    exp_t e;
    cur = 64'({bus.out_valid_o, bus.sign_o, bus.sf_o, bus.mts_o,
               bus.ovf_o, bus.udf_o, bus.nzero_o});
    if (was_stall) chk("stall_hold", cur, held);
    was_stall = (bus.out_valid_o === 1'b1) && !bus.out_ready_i && !rst && !bus.flush_i;
    held = cur;
    if (!rst && !bus.flush_i && bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
      if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("sign", 64'(bus.sign_o), 64'(e.sign));
        chk("sf", $signed(bus.sf_o), 64'(e.sf));
        chk("mts", 64'(bus.mts_o), 64'(e.mts));
        chk("ovf", 64'(bus.ovf_o), 64'(e.ovf));
        chk("udf", 64'(bus.udf_o), 64'(e.udf));
        chk("nzero", 64'(bus.nzero_o), 64'(e.nzero));
`ifdef FRAC_SF_STICKY_EN
        chk("sticky", 64'(bus.sticky_o), 64'(e.sticky));
`endif
      end
    end
    if (bus.in_valid_i && bus.in_ready_o === 1'b1)
      q.push_back(model(bus.acc_sign_i, bus.acc_hd_i, bus.acc_s0_i,
                        bus.acc_s1_i, bus.acc_s2_i, bus.acc_s3_i));
    if (rst || bus.flush_i) q.delete();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic sg, logic [HEAD-1:0] hd, logic [ACC-1:0] s0,
                       logic [ACC-1:0] s1, logic [ACC-1:0] s2, logic [ACC-1:0] s3);
    bus.acc_sign_i = sg; bus.acc_hd_i = hd;
    bus.acc_s0_i = s0; bus.acc_s1_i = s1; bus.acc_s2_i = s2; bus.acc_s3_i = s3;
  endtask

  task automatic one(logic sg, logic [HEAD-1:0] hd, logic [ACC-1:0] s0,
                     logic [ACC-1:0] s1, logic [ACC-1:0] s2, logic [ACC-1:0] s3);
    drive(sg, hd, s0, s1, s2, s3);
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    chk("lat_not_early", 64'(bus.out_valid_o), 64'd0);
    step();
    chk("lat_valid", 64'(bus.out_valid_o), 64'd1);
  endtask

  task automatic rand_beat();
    int c;
    logic [ACC-1:0] s0, s1, s2, s3, nz;
    logic [HEAD-1:0] hd;
    c  = $urandom_range(0, 5);
    hd = HEAD'($urandom);
    s0 = ACC'($urandom); s1 = ACC'($urandom); s2 = ACC'($urandom); s3 = ACC'($urandom);
    nz = (ACC'($urandom) | 24'h800000) >> $urandom_range(0, ACC-1);
    case (c)
      0: hd = hd | 1;
      1: begin hd = 0; s0 = nz; end
      2: begin hd = 0; s0 = 0; s1 = nz; end
      3: begin hd = 0; s0 = 0; s1 = 0; s2 = nz; end
      4: begin hd = 0; s0 = 0; s1 = 0; s2 = 0; s3 = nz; end
      default: begin hd = 0; s0 = 0; s1 = 0; s2 = 0; s3 = 0; end
    endcase
    drive(1'($urandom), hd, s0, s1, s2, s3);
  endtask

  initial begin
    int n, cyc;
    logic [3:0] pat;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    // reset state
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_sf", $signed(bus.sf_o), 64'd0);
    chk("rst_mts", 64'(bus.mts_o), 64'd0);
    chk("rst_flags", 64'({bus.sign_o, bus.ovf_o, bus.udf_o, bus.nzero_o}), 64'b0001);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    chk("idle_in_ready", 64'(bus.in_ready_o), 64'd1);

    // positive segment
    one(0, 0, 0, 24'h000100, 0, 0);
    chk("pos_sf", $signed(bus.sf_o), 64'd8);
    chk("pos_mts", 64'(bus.mts_o), 64'h80);
    chk("pos_flags", 64'({bus.ovf_o, bus.udf_o, bus.nzero_o}), 64'b001);
`ifdef FRAC_SF_STICKY_EN
    chk("pos_sticky", 64'(bus.sticky_o), 64'd0);
`endif
    // negative segment with residue in s3
    one(1, 0, 0, 0, 24'h400000, 24'h000001);
    chk("neg_sf", $signed(bus.sf_o), -64'sd2);
    chk("neg_mts", 64'(bus.mts_o), 64'h80);
    chk("neg_sign", 64'(bus.sign_o), 64'd1);
`ifdef FRAC_SF_STICKY_EN
    chk("neg_sticky", 64'(bus.sticky_o), 64'd1);
`endif
    one(0, 6'd1, 0, 0, 0, 0);
    chk("ovf_flags", 64'({bus.ovf_o, bus.udf_o, bus.nzero_o}), 64'b101);
    chk("ovf_sf_mts", 64'({bus.sf_o, bus.mts_o}), 64'd0);
    one(0, 0, 0, 0, 0, 24'd5);
    chk("udf_flags", 64'({bus.ovf_o, bus.udf_o, bus.nzero_o}), 64'b011);
    one(0, 0, 0, 0, 0, 0);
    chk("zero_flags", 64'({bus.ovf_o, bus.udf_o, bus.nzero_o}), 64'b010);
    step();

    // 8 back-to-back beats, out_ready pattern 1,0,0,1
    pat = 4'b1001;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 200) begin
      if (cyc == 0 || bus.in_ready_o) rand_beat();
      bus.in_valid_i = 1'b1;
      bus.out_ready_i = pat[3 - (cyc % 4)];
      @(negedge clk);
      if (bus.in_ready_o) n++;
      step();
      cyc++;
    end
    chk("b2b_accepted", 64'(n), 64'd8);
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin step(); cyc++; end
    chk("b2b_drain", 64'(q.size()), 64'd0);

    // flush with two beats in flight
    bus.out_ready_i = 1'b0;
    drive(0, 0, 0, 24'h00ABCD, 0, 0); bus.in_valid_i = 1'b1; step();
    drive(0, 0, 0, 0, 24'h001234, 0); step();
    chk("pre_flush_valid", 64'(bus.out_valid_o), 64'd1);
    bus.flush_i = 1'b1;
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'd0);
    step();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    bus.out_ready_i = 1'b1;
    step(); step();
    chk("flush_no_emit", 64'(bus.out_valid_o), 64'd0);

    // reset with two beats in flight
    bus.out_ready_i = 1'b0;
    drive(1, 0, 0, 24'h000F00, 0, 0); bus.in_valid_i = 1'b1; step();
    drive(0, 0, 0, 0, 24'h0000F0, 0); step();
    rst = 1'b1; bus.flush_i = 1'b1;
    chk("rst_mid_in_ready", 64'(bus.in_ready_o), 64'd0);
    step();
    rst = 1'b0; bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    chk("rst_mid_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_mid_vals", 64'({bus.sign_o, bus.sf_o, bus.mts_o, bus.ovf_o, bus.udf_o, bus.nzero_o}), 64'd1);
    bus.out_ready_i = 1'b1;
    step(); step();
    chk("rst_no_emit", 64'(bus.out_valid_o), 64'd0);

    // random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      bus.in_valid_i  = 1'($urandom_range(0, 1));
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin step(); cyc++; end
    chk("rand_drain", 64'(q.size()), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
